product_inventory: RTL and testbench

- Stock array of the vending machine: one 4-bit item count per product slot.
- Feeds the currently selected slot's count to the owner-charge stage and writes back the value that stage returns.
- Services customer purchases (decrement with sold-out detection) and runs an owner stock-scan sequence.
- Sits between the mode/keypad controller and the owner-charge / dispense stages.

---
 rtl/product_inventory_if.sv | 31 +++
 rtl/product_inventory.sv | 125 ++++++++++++
 tb/tb_product_inventory.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/product_inventory_if.sv
// Bus between the mode/keypad controller, the charge stage and the stock array.
// Carries slot selection, charge write-back data, buy handshake and scan results.
interface product_inventory_if #(
  parameter int unsigned SLOTS = 8,
  parameter int unsigned SEL_W = 3
);
  logic [1:0]       mode;
  logic [SEL_W-1:0] sel;
  logic [3:0]       supply_out;
  logic [3:0]       supply_in;
  logic             buy_req;
  logic             dispense;
  logic             sold_out;
  logic             scan_valid;
  logic [SEL_W-1:0] scan_idx;
  logic             scan_empty;
  logic             scan_done;
  logic [SLOTS-1:0] empty_mask;

  modport master (
    output mode, sel, supply_in, buy_req,
    input  supply_out, dispense, sold_out, scan_valid, scan_idx,
           scan_empty, scan_done, empty_mask
  );

  modport slave (
    input  mode, sel, supply_in, buy_req,
    output supply_out, dispense, sold_out, scan_valid, scan_idx,
           scan_empty, scan_done, empty_mask
  );
endinterface

// File: rtl/product_inventory.sv
// Vending-machine stock array: per-slot 4-bit counts, charge write-back,
// customer purchase with sold-out detection, and owner stock scan.
module product_inventory #(
  parameter int unsigned SLOTS      = 8,
  parameter int unsigned SEL_W      = 3,
  parameter logic [3:0]  INIT_STOCK = 4'd5
) (
  input  logic              clk,
  input  logic              rst,
  product_inventory_if.slave bus
);
  localparam int unsigned CNT_W = 4;
  localparam logic [1:0] MODE_BUY    = 2'b01;
  localparam logic [1:0] MODE_CHARGE = 2'b10;
  localparam logic [1:0] MODE_SCAN   = 2'b11;

  typedef enum logic [1:0] {IDLE, BUY_EVAL, BUY_RESP, SCAN} state_e;

  state_e                       state_q, state_d;
  logic [SLOTS-1:0][CNT_W-1:0]  stock_q, stock_d;
  logic [SLOTS-1:0]             mask_q, mask_d;
  logic [SEL_W-1:0]             buy_sel_q, buy_sel_d;
  logic [SEL_W-1:0]             wb_sel_q;
  logic                         wb_pend_q;
  logic                         dispense_q, dispense_d;
  logic                         sold_out_q, sold_out_d;
  logic                         scan_valid_q, scan_valid_d;
  logic                         scan_done_q, scan_done_d;
  logic [SEL_W-1:0]             scan_idx_q, scan_idx_d;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state, stock update and pulse outputs; charge write-back lands last
  always_comb begin
    state_d      = state_q;
    stock_d      = stock_q;
    buy_sel_d    = buy_sel_q;
    dispense_d   = 1'b0;
    sold_out_d   = 1'b0;
    scan_valid_d = 1'b0;
    scan_done_d  = 1'b0;
    scan_idx_d   = scan_idx_q;
    case (state_q)
      IDLE: begin
        if (bus.mode == MODE_BUY && bus.buy_req && !wb_pend_q) begin
          state_d   = BUY_EVAL;
          buy_sel_d = bus.sel;
        end else if (bus.mode == MODE_SCAN) begin
          state_d      = SCAN;
          scan_valid_d = 1'b1;
          scan_idx_d   = '0;
        end
      end
      BUY_EVAL: begin
        if (stock_q[buy_sel_q] != '0) begin
          stock_d[buy_sel_q] = stock_q[buy_sel_q] - CNT_W'(1);
          dispense_d         = 1'b1;
        end else begin
          sold_out_d = 1'b1;
        end
        state_d = BUY_RESP;
      end
      BUY_RESP: begin
        if (!bus.buy_req) state_d = IDLE;
      end
      SCAN: begin
        if (bus.mode != MODE_SCAN) begin
          state_d = IDLE;
        end else if (scan_idx_q == SEL_W'(SLOTS - 1)) begin
          scan_done_d = 1'b1;
          state_d     = IDLE;
        end else begin
          scan_valid_d = 1'b1;
          scan_idx_d   = scan_idx_q + SEL_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (wb_pend_q) stock_d[wb_sel_q] = bus.supply_in;
  end

  always_comb begin
    mask_d = '0;
    for (int unsigned i = 0; i < SLOTS; i++) mask_d[i] = (stock_q[i] == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stock_q      <= {SLOTS{INIT_STOCK}};
      mask_q       <= {SLOTS{INIT_STOCK == 4'd0}};
      buy_sel_q    <= '0;
      wb_sel_q     <= '0;
      wb_pend_q    <= 1'b0;
      dispense_q   <= 1'b0;
      sold_out_q   <= 1'b0;
      scan_valid_q <= 1'b0;
      scan_done_q  <= 1'b0;
      scan_idx_q   <= '0;
    end else begin
      stock_q      <= stock_d;
      mask_q       <= mask_d;
      buy_sel_q    <= buy_sel_d;
      wb_sel_q     <= bus.sel;
      wb_pend_q    <= (bus.mode == MODE_CHARGE);
      dispense_q   <= dispense_d;
      sold_out_q   <= sold_out_d;
      scan_valid_q <= scan_valid_d;
      scan_done_q  <= scan_done_d;
      scan_idx_q   <= scan_idx_d;
    end
  end

  assign bus.supply_out = stock_q[bus.sel];
  assign bus.dispense   = dispense_q;
  assign bus.sold_out   = sold_out_q;
  assign bus.scan_valid = scan_valid_q;
  assign bus.scan_idx   = scan_idx_q;
  assign bus.scan_empty = scan_valid_q && (stock_q[scan_idx_q] == '0);
  assign bus.scan_done  = scan_done_q;
  assign bus.empty_mask = mask_q;
endmodule

// File: tb/tb_product_inventory.sv
// Directed bench for product_inventory: reset, charge write-back, buy,
// deferred buy, stock scan with abort, and reset mid-transaction.
module tb_product_inventory;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  product_inventory_if #(.SLOTS(8), .SEL_W(3)) bus ();

  product_inventory #(.SLOTS(8), .SEL_W(3), .INIT_STOCK(4'd5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulses(input string tag, input logic d, input logic s);
    chk({tag, "_dispense"}, 32'(bus.dispense), 32'(d));
    chk({tag, "_sold_out"}, 32'(bus.sold_out), 32'(s));
  endtask

  // Charge write-back: mode=10 for one cycle, result presented the next cycle
  task automatic charge(input logic [2:0] slot, input logic [3:0] val);
    bus.mode = 2'b10; bus.sel = slot;
    step();
    bus.mode = 2'b00; bus.supply_in = val;
    step();
  endtask

  task automatic peek(input string tag, input logic [2:0] slot, input logic [3:0] exp);
    bus.sel = slot;
    #1;
    chk(tag, 32'(bus.supply_out), 32'(exp));
  endtask

  initial begin
    bus.mode = 2'b00; bus.sel = '0; bus.supply_in = '0; bus.buy_req = 1'b0;

    // Reset state
    #2;
    pulses("rst", 1'b0, 1'b0);
    chk("rst_scan_valid", 32'(bus.scan_valid), 32'd0);
    chk("rst_scan_done", 32'(bus.scan_done), 32'd0);
    chk("rst_scan_idx", 32'(bus.scan_idx), 32'd0);
    step(); step();
    rst = 1'b0;
    step();
    for (int i = 0; i < 8; i++) peek($sformatf("init_slot%0d", i), 3'(i), 4'd5);
    chk("init_mask", 32'(bus.empty_mask), 32'h00);

    // Charge write-back on slot 3
    charge(3'd3, 4'd9);
    peek("wb_slot3", 3'd3, 4'd9);
    peek("wb_slot2", 3'd2, 4'd5);
    peek("wb_slot4", 3'd4, 4'd5);

    // Buy from count 1 on slot 2 with request held 5 cycles
    charge(3'd2, 4'd1);
    peek("buy_pre", 3'd2, 4'd1);
    bus.mode = 2'b01; bus.buy_req = 1'b1;
    step();
    pulses("buy_c1", 1'b0, 1'b0);
    step();
    pulses("buy_c2", 1'b1, 1'b0);
    chk("buy_cnt", 32'(bus.supply_out), 32'd0);
    step();
    pulses("buy_c3", 1'b0, 1'b0);
    chk("buy_mask", 32'(bus.empty_mask), 32'h04);
    step();
    pulses("buy_c4", 1'b0, 1'b0);
    step();
    pulses("buy_c5", 1'b0, 1'b0);
    chk("buy_cnt_held", 32'(bus.supply_out), 32'd0);
    bus.buy_req = 1'b0;
    step();
    // Second request on the empty slot
    bus.buy_req = 1'b1;
    step();
    pulses("so_c1", 1'b0, 1'b0);
    step();
    pulses("so_c2", 1'b0, 1'b1);
    chk("so_cnt", 32'(bus.supply_out), 32'd0);
    bus.buy_req = 1'b0;
    step();
    pulses("so_c3", 1'b0, 1'b0);

    // Buy deferred behind a write-back on the same slot (5 -> 9 -> 8)
    bus.mode = 2'b10; bus.sel = 3'd5;
    step();
    bus.mode = 2'b01; bus.buy_req = 1'b1; bus.supply_in = 4'd9;
    step();
    pulses("def_c1", 1'b0, 1'b0);
    chk("def_wb", 32'(bus.supply_out), 32'd9);
    step();
    pulses("def_c2", 1'b0, 1'b0);
    step();
    pulses("def_c3", 1'b1, 1'b0);
    chk("def_cnt", 32'(bus.supply_out), 32'd8);
    bus.buy_req = 1'b0; bus.mode = 2'b00;
    step();
    pulses("def_c4", 1'b0, 1'b0);

    // Full scan with slots 1 and 6 empty
    charge(3'd2, 4'd3);
    charge(3'd1, 4'd0);
    charge(3'd6, 4'd0);
    step();
    chk("scan_mask", 32'(bus.empty_mask), 32'h42);
    bus.mode = 2'b11;
    step();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("scan_valid%0d", i), 32'(bus.scan_valid), 32'd1);
      chk($sformatf("scan_idx%0d", i), 32'(bus.scan_idx), 32'(i));
      chk($sformatf("scan_empty%0d", i), 32'(bus.scan_empty), 32'((i == 1) || (i == 6)));
      chk($sformatf("scan_ndone%0d", i), 32'(bus.scan_done), 32'd0);
      step();
    end
    chk("scan_done", 32'(bus.scan_done), 32'd1);
    chk("scan_end_valid", 32'(bus.scan_valid), 32'd0);
    bus.mode = 2'b00;
    step();
    chk("scan_done_clr", 32'(bus.scan_done), 32'd0);

    // Scan aborted at index 4
    bus.mode = 2'b11;
    step();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("abort_idx%0d", i), 32'(bus.scan_idx), 32'(i));
      if (i == 4) bus.mode = 2'b00;
      step();
    end
    chk("abort_valid", 32'(bus.scan_valid), 32'd0);
    chk("abort_done", 32'(bus.scan_done), 32'd0);
    step();
    chk("abort_done2", 32'(bus.scan_done), 32'd0);

    // Reset asserted during BUY_EVAL
    bus.mode = 2'b01; bus.sel = 3'd0; bus.buy_req = 1'b1;
    step();
    rst = 1'b1;
    #1;
    pulses("rbuy_now", 1'b0, 1'b0);
    chk("rbuy_mask", 32'(bus.empty_mask), 32'h00);
    peek("rbuy_slot0", 3'd0, 4'd5);
    peek("rbuy_slot5", 3'd5, 4'd5);
    peek("rbuy_slot6", 3'd6, 4'd5);
    step();
    rst = 1'b0; bus.buy_req = 1'b0; bus.mode = 2'b00;
    step();
    pulses("rbuy_c1", 1'b0, 1'b0);
    step();
    pulses("rbuy_c2", 1'b0, 1'b0);
    peek("rbuy_slot0_after", 3'd0, 4'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
